// File: rtl/mont_exp_ctrl.sv
// Left-to-right binary modular exponentiation sequencer driving an external Montgomery core.
// Leading exponent zeros are skipped in SCAN before any core operation is issued.
module mont_exp_ctrl #(
  parameter int WIDTH    = 1024,
  parameter int EXP_BITS = 1024,
  localparam int OPW  = $clog2(2*EXP_BITS+2),
  localparam int IDXW = (EXP_BITS > 1) ? $clog2(EXP_BITS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    in_x,
  input  logic [WIDTH-1:0]    in_r,
  input  logic [EXP_BITS-1:0] in_e,
  input  logic [WIDTH-1:0]    in_m,
  output logic [WIDTH-1:0]    result,
  output logic                done,
  output logic                busy,
  output logic [OPW-1:0]      op_count,
  output logic                mm_start,
  output logic [WIDTH-1:0]    mm_a,
  output logic [WIDTH-1:0]    mm_b,
  output logic [WIDTH-1:0]    mm_m,
  input  logic [WIDTH-1:0]    mm_result,
  input  logic                mm_done
);

  typedef enum logic [2:0] {
    IDLE, SCAN, SQ_ISSUE, SQ_WAIT, MUL_ISSUE, MUL_WAIT, FIN_ISSUE, FIN_WAIT
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    x_q, x_d, r_q, r_d, a_q, a_d;
  logic [EXP_BITS-1:0] e_q, e_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic [OPW-1:0]      op_count_q, op_count_d;
  logic                mm_start_q, mm_start_d;
  logic [WIDTH-1:0]    mm_a_q, mm_a_d, mm_b_q, mm_b_d, mm_m_q, mm_m_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic                done_q, done_d;
  logic                last_bit;

  assign last_bit = (idx_q == '0);

  // mm_m_q doubles as the latched modulus; operands only change in issue states,
  // so they stay stable from mm_start through the cycle after mm_done.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    r_d        = r_q;
    e_d        = e_q;
    idx_d      = idx_q;
    a_d        = a_q;
    op_count_d = op_count_q;
    mm_start_d = 1'b0;
    mm_a_d     = mm_a_q;
    mm_b_d     = mm_b_q;
    mm_m_d     = mm_m_q;
    result_d   = result_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          x_d        = in_x;
          r_d        = in_r;
          e_d        = in_e;
          mm_m_d     = in_m;
          idx_d      = IDXW'(EXP_BITS - 1);
          op_count_d = '0;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        if (e_q[idx_q]) begin
          a_d = x_q;
          if (last_bit) begin
            state_d = FIN_ISSUE;
          end else begin
            idx_d   = idx_q - 1'b1;
            state_d = SQ_ISSUE;
          end
        end else if (last_bit) begin
          a_d     = r_q;
          state_d = FIN_ISSUE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      SQ_ISSUE: begin
        mm_start_d = 1'b1;
        mm_a_d     = a_q;
        mm_b_d     = a_q;
        op_count_d = op_count_q + 1'b1;
        state_d    = SQ_WAIT;
      end
      SQ_WAIT: begin
        if (mm_done) begin
          a_d = mm_result;
          if (e_q[idx_q]) begin
            state_d = MUL_ISSUE;
          end else if (last_bit) begin
            state_d = FIN_ISSUE;
          end else begin
            idx_d   = idx_q - 1'b1;
            state_d = SQ_ISSUE;
          end
        end
      end
      MUL_ISSUE: begin
        mm_start_d = 1'b1;
        mm_a_d     = a_q;
        mm_b_d     = x_q;
        op_count_d = op_count_q + 1'b1;
        state_d    = MUL_WAIT;
      end
      MUL_WAIT: begin
        if (mm_done) begin
          a_d = mm_result;
          if (last_bit) begin
            state_d = FIN_ISSUE;
          end else begin
            idx_d   = idx_q - 1'b1;
            state_d = SQ_ISSUE;
          end
        end
      end
      // Multiplying by plain 1 strips the Montgomery factor from the accumulator.
      FIN_ISSUE: begin
        mm_start_d = 1'b1;
        mm_a_d     = a_q;
        mm_b_d     = WIDTH'(1);
        op_count_d = op_count_q + 1'b1;
        state_d    = FIN_WAIT;
      end
      FIN_WAIT: begin
        if (mm_done) begin
          result_d = mm_result;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      x_q        <= '0;
      r_q        <= '0;
      e_q        <= '0;
      idx_q      <= '0;
      a_q        <= '0;
      op_count_q <= '0;
      mm_start_q <= 1'b0;
      mm_a_q     <= '0;
      mm_b_q     <= '0;
      mm_m_q     <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      r_q        <= r_d;
      e_q        <= e_d;
      idx_q      <= idx_d;
      a_q        <= a_d;
      op_count_q <= op_count_d;
      mm_start_q <= mm_start_d;
      mm_a_q     <= mm_a_d;
      mm_b_q     <= mm_b_d;
      mm_m_q     <= mm_m_d;
      result_q   <= result_d;
      done_q     <= done_d;
    end
  end

  assign result   = result_q;
  assign done     = done_q;
  assign busy     = (state_q != IDLE);
  assign op_count = op_count_q;
  assign mm_start = mm_start_q;
  assign mm_a     = mm_a_q;
  assign mm_b     = mm_b_q;
  assign mm_m     = mm_m_q;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Bench for mont_exp_ctrl: behavioural 5-cycle Montgomery core plus a plain square-and-multiply
// reference for x^e mod m and the expected operation count.
module tb_mont_exp_ctrl;

  localparam int W   = 16;
  localparam int EB  = 8;
  localparam int OPW = $clog2(2*EB+2);

  logic           clk = 1'b0;
  logic           rst, start;
  logic [W-1:0]   in_x, in_r, in_m;
  logic [EB-1:0]  in_e;
  logic [W-1:0]   result, mm_a, mm_b, mm_m;
  logic           done, busy, mm_start;
  logic [OPW-1:0] op_count;
  logic [W-1:0]   mm_result = '0;
  logic           core_done = 1'b0;
  logic           spur_done;
  wire            mm_done = core_done | spur_done;

  int checks = 0;
  int failures = 0;

  int start_cnt = 0, done_cnt = 0, stab_err = 0, m_err = 0, pulse_err = 0;
  int base_starts, base_dones, exp_ops;
  logic [W-1:0] exp_res, cur_m = '0;

  mont_exp_ctrl #(.WIDTH(W), .EXP_BITS(EB)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_x(in_x), .in_r(in_r), .in_e(in_e), .in_m(in_m),
    .result(result), .done(done), .busy(busy), .op_count(op_count),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
    .mm_result(mm_result), .mm_done(mm_done)
  );

  always #5 clk = ~clk;

  function automatic longint unsigned rinv_of(longint unsigned m);
    for (longint unsigned k = 1; k < m; k++)
      if (((k << 16) % m) == 64'd1) return k;
    return 64'd0;
  endfunction

  function automatic logic [W-1:0] ref_modexp(longint unsigned x, int unsigned e, longint unsigned m);
    longint unsigned r = 1, b = x % m;
    for (int i = 0; i < EB; i++) begin
      if (e[i]) r = (r * b) % m;
      b = (b * b) % m;
    end
    return W'(r % m);
  endfunction

  function automatic int ref_ops(int unsigned e);
    int msb = 0, pop = 0;
    if (e == 0) return 1;
    for (int i = 0; i < EB; i++) if (e[i]) begin msb = i; pop++; end
    return msb + pop;
  endfunction

  // Behavioural core: product returned exactly 5 cycles after mm_start; also watches bus rules.
  longint unsigned rinv_m = 0, rinv = 0;
  bit pend = 0, prev_start = 0;
  int cnt = 0;
  logic [W-1:0] pa, pb, pm, pval;
  always @(negedge clk) begin
    longint unsigned aa, bb, mm;
    core_done = 1'b0;
    if (done) done_cnt++;
    if (busy && mm_m !== cur_m) m_err++;
    if (mm_start && prev_start) pulse_err++;
    prev_start = mm_start;
    if (mm_start) begin
      start_cnt++;
      aa = mm_a; bb = mm_b; mm = mm_m;
      if (mm != rinv_m) begin rinv_m = mm; rinv = rinv_of(mm); end
      pval = (mm == 0) ? '0 : W'((((aa * bb) % mm) * rinv) % mm);
      pa = mm_a; pb = mm_b; pm = mm_m;
      pend = 1; cnt = 5;
    end else if (pend) begin
      if (busy && (mm_a !== pa || mm_b !== pb || mm_m !== pm)) stab_err++;
      cnt--;
      if (cnt == 0) begin core_done = 1'b1; mm_result = pval; pend = 0; end
    end
  end

  task automatic drive_start(input int unsigned x, input int unsigned e, input int unsigned m);
    longint unsigned xl = x, ml = m;
    #1;
    in_x = W'((xl << 16) % ml);
    in_r = W'((64'd1 << 16) % ml);
    in_e = EB'(e);
    in_m = W'(m);
    cur_m = W'(m);
    exp_res = ref_modexp(xl, e, ml);
    exp_ops = ref_ops(e);
    base_starts = start_cnt;
    base_dones = done_cnt;
    start = 1'b1;
  endtask

  task automatic wait_done(output bit timed_out);
    int cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!done && cycles < 3000);
    timed_out = !done;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got %b want 0", done); end
    checks++; if (result !== '0) begin failures++; $display("[TB] FAIL reset_result got %0d want 0", result); end
    checks++; if (op_count !== '0) begin failures++; $display("[TB] FAIL reset_opcount got %0d want 0", op_count); end
    checks++; if ({mm_start, mm_a, mm_b, mm_m} !== '0) begin failures++; $display("[TB] FAIL reset_core_if got %h want 0", {mm_start, mm_a, mm_b, mm_m}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    int unsigned xs[4] = '{3, 5, 7, 2};
    int unsigned es[4] = '{5, 0, 1, 255};
    int unsigned ms[4] = '{13, 13, 13, 251};
    bit to;
    foreach (xs[i]) begin
      @(negedge clk);
      drive_start(xs[i], es[i], ms[i]);
      @(negedge clk);
      start = 1'b0;
      wait_done(to);
      checks++; if (to) begin failures++; $display("[TB] FAIL directed_timeout vec=%0d got no done want done", i); end
      checks++; if (result !== exp_res) begin failures++; $display("[TB] FAIL directed_result vec=%0d got %0d want %0d", i, result, exp_res); end
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL directed_busy_at_done vec=%0d got %b want 0", i, busy); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL directed_done_width vec=%0d got %b want 0", i, done); end
      @(negedge clk);
      #1;
      checks++; if (op_count !== OPW'(exp_ops)) begin failures++; $display("[TB] FAIL directed_opcount vec=%0d got %0d want %0d", i, op_count, exp_ops); end
      checks++; if (start_cnt - base_starts != exp_ops) begin failures++; $display("[TB] FAIL directed_mm_starts vec=%0d got %0d want %0d", i, start_cnt - base_starts, exp_ops); end
      checks++; if (done_cnt - base_dones != 1) begin failures++; $display("[TB] FAIL directed_done_pulses vec=%0d got %0d want 1", i, done_cnt - base_dones); end
    end
  endtask

  task automatic test_random();
    bit to;
    for (int i = 0; i < 8; i++) begin
      int unsigned m = $urandom_range(1, 32767) * 2 + 1;
      int unsigned x = $urandom_range(0, m - 1);
      int unsigned e = $urandom_range(0, 255);
      @(negedge clk);
      drive_start(x, e, m);
      @(negedge clk);
      start = 1'b0;
      wait_done(to);
      checks++; if (to || result !== exp_res) begin failures++; $display("[TB] FAIL random_result x=%0d e=%0d m=%0d got %0d want %0d", x, e, m, result, exp_res); end
      @(negedge clk);
      #1;
      checks++; if (op_count !== OPW'(exp_ops)) begin failures++; $display("[TB] FAIL random_opcount e=%0d got %0d want %0d", e, op_count, exp_ops); end
      checks++; if (start_cnt - base_starts != exp_ops) begin failures++; $display("[TB] FAIL random_mm_starts e=%0d got %0d want %0d", e, start_cnt - base_starts, exp_ops); end
    end
  endtask

  task automatic test_busy_ignore();
    bit to;
    int unsigned m = $urandom_range(1, 32767) * 2 + 1;
    @(negedge clk);
    drive_start($urandom_range(0, m - 1), 8'hB5, m);
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL busy_mid_run got %b want 1", busy); end
    start = 1'b1;
    in_e = ~in_e;
    in_x = W'($urandom);
    in_r = W'($urandom);
    in_m = W'($urandom) | W'(1);
    @(negedge clk);
    start = 1'b0;
    wait_done(to);
    checks++; if (to || result !== exp_res) begin failures++; $display("[TB] FAIL busy_ignore_result got %0d want %0d", result, exp_res); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (op_count !== OPW'(exp_ops)) begin failures++; $display("[TB] FAIL busy_ignore_opcount got %0d want %0d", op_count, exp_ops); end
    checks++; if (busy !== 1'b0 || done_cnt - base_dones != 1) begin failures++; $display("[TB] FAIL busy_ignore_restart busy=%b dones=%0d want busy=0 dones=1", busy, done_cnt - base_dones); end
  endtask

  task automatic test_spurious_done();
    bit to;
    int base;
    @(negedge clk);
    #1;
    base = done_cnt;
    spur_done = 1'b1;
    repeat (2) @(negedge clk);
    spur_done = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (done_cnt != base || busy !== 1'b0) begin failures++; $display("[TB] FAIL spurious_idle dones=%0d busy=%b want dones=0 busy=0", done_cnt - base, busy); end
    drive_start(9, 0, 13);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    spur_done = 1'b1;
    repeat (3) @(negedge clk);
    spur_done = 1'b0;
    wait_done(to);
    checks++; if (to || result !== W'(1)) begin failures++; $display("[TB] FAIL spurious_scan_result got %0d want 1", result); end
    @(negedge clk);
    #1;
    checks++; if (op_count !== OPW'(1) || start_cnt - base_starts != 1) begin failures++; $display("[TB] FAIL spurious_scan_ops got %0d/%0d want 1/1", op_count, start_cnt - base_starts); end
  endtask

  task automatic test_reset_mid_run();
    bit to;
    int cycles = 0;
    int base;
    @(negedge clk);
    drive_start(3, 5, 13);
    @(negedge clk);
    start = 1'b0;
    while (start_cnt - base_starts < 3 && cycles < 500) begin
      @(negedge clk);
      cycles++;
    end
    checks++; if (start_cnt - base_starts < 3) begin failures++; $display("[TB] FAIL rst_mid_reach_mul got %0d ops want 3", start_cnt - base_starts); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_flags busy=%b done=%b want 0 0", busy, done); end
    checks++; if (result !== '0 || op_count !== '0) begin failures++; $display("[TB] FAIL rst_mid_regs result=%0d op_count=%0d want 0 0", result, op_count); end
    checks++; if ({mm_start, mm_a, mm_b, mm_m} !== '0) begin failures++; $display("[TB] FAIL rst_mid_core_if got %h want 0", {mm_start, mm_a, mm_b, mm_m}); end
    base = done_cnt;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    checks++; if (done_cnt != base || busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_late_done dones=%0d busy=%b want 0 0", done_cnt - base, busy); end
    drive_start(4, 6, 11);
    @(negedge clk);
    start = 1'b0;
    wait_done(to);
    checks++; if (to || result !== exp_res) begin failures++; $display("[TB] FAIL rst_mid_next_run got %0d want %0d", result, exp_res); end
    @(negedge clk);
    #1;
    checks++; if (op_count !== OPW'(exp_ops)) begin failures++; $display("[TB] FAIL rst_mid_next_ops got %0d want %0d", op_count, exp_ops); end
  endtask

  task automatic test_back_to_back();
    bit to;
    @(negedge clk);
    drive_start(3, 5, 13);
    @(negedge clk);
    start = 1'b0;
    wait_done(to);
    checks++; if (to || result !== W'(9)) begin failures++; $display("[TB] FAIL b2b_first got %0d want 9", result); end
    drive_start(6, 8'h2D, 251);
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL b2b_accept busy got %b want 1", busy); end
    wait_done(to);
    checks++; if (to || result !== exp_res) begin failures++; $display("[TB] FAIL b2b_second got %0d want %0d", result, exp_res); end
    @(negedge clk);
    #1;
    checks++; if (op_count !== OPW'(exp_ops)) begin failures++; $display("[TB] FAIL b2b_second_ops got %0d want %0d", op_count, exp_ops); end
  endtask

  task automatic test_operand_stability();
    checks++; if (stab_err != 0) begin failures++; $display("[TB] FAIL operand_stability got %0d violations want 0", stab_err); end
    checks++; if (m_err != 0) begin failures++; $display("[TB] FAIL modulus_while_busy got %0d violations want 0", m_err); end
    checks++; if (pulse_err != 0) begin failures++; $display("[TB] FAIL mm_start_width got %0d long pulses want 0", pulse_err); end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    spur_done = 1'b0;
    in_x = '0;
    in_r = '0;
    in_e = '0;
    in_m = '0;
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_spurious_done();
    test_reset_mid_run();
    test_back_to_back();
    test_operand_stability();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mont_exp_ctrl.md
MONT_EXP_CTRL -- requirements
Module: mont_exp_ctrl

Interface
REQ-001 Parameter WIDTH, 1024, operand/modulus width in bits.
REQ-002 Parameter EXP_BITS, 1024, exponent width in bits.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  clock; all state changes on rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 start  in  1  request pulse; accepted only in IDLE.
REQ-007 in_x  in  WIDTH  base in Montgomery form (x*R mod m).
REQ-008 in_r  in  WIDTH  Montgomery one (R mod m).
REQ-009 in_e  in  EXP_BITS  exponent.
REQ-010 in_m  in  WIDTH  modulus, odd.
REQ-011 result  out  WIDTH  x^e mod m in normal (non-Montgomery) form; holds until next done.
REQ-012 done  out  1  one-cycle pulse when result is updated.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 op_count  out  clog2(2*EXP_BITS+2)  number of core operations issued in the current/last run.
REQ-015 mm_start  out  1  one-cycle start pulse to the Montgomery core.
REQ-016 mm_a, mm_b, mm_m  out  WIDTH  core operands.
REQ-017 mm_result  in  WIDTH  core product a*b*R^-1 mod m.
REQ-018 mm_done  in  1  core completion; mm_result is valid in the same cycle.

Function
REQ-019 States SHALL be IDLE, SCAN, SQ, MUL, FIN, each core state (SQ/MUL/FIN) having an issue cycle and a wait phase.
REQ-020 On start in IDLE: latch in_x, in_r, in_e, in_m into internal registers; idx <= EXP_BITS-1; op_count <= 0; go SCAN.
REQ-021 SCAN examines one exponent bit per cycle (leading-zero skip): bit 1 -> A <= X, then FIN if idx==0, else idx-1 and SQ; bit 0 and idx==0 -> A <= R, FIN; bit 0 otherwise -> idx-1, stay.
REQ-022 SQ issue: mm_a=mm_b=A, mm_start=1 for exactly one cycle, op_count+1; wait for mm_done.
REQ-023 SQ on mm_done: A <= mm_result; e[idx]=1 -> MUL; else idx==0 -> FIN, else idx-1 -> SQ.
REQ-024 MUL issue: mm_a=A, mm_b=X, one mm_start pulse, op_count+1; on mm_done A <= mm_result; idx==0 -> FIN, else idx-1 -> SQ.
REQ-025 FIN issue: mm_a=A, mm_b=1, one mm_start pulse, op_count+1; on mm_done result <= mm_result, done=1 next cycle, go IDLE.
REQ-026 mm_a, mm_b, mm_m SHALL be valid in the mm_start cycle and held stable until the cycle after mm_done.
REQ-027 mm_m SHALL equal the latched modulus whenever busy.
REQ-028 The first mm_start SHALL be issued no earlier than the cycle after SCAN exits.
REQ-029 start while busy SHALL be ignored; input changes while busy SHALL NOT affect the run.
REQ-030 mm_done outside a wait phase SHALL be ignored.
REQ-031 e=0 SHALL produce exactly one core op (FIN on R) giving result 1.
REQ-032 Core ops per run = 1 + (number of SQ) + popcount(e) - 1 for e != 0, where SQ count = index of msb(e).
REQ-033 done and start in the same cycle: done completes, start is accepted (state is IDLE in that cycle).

Reset
REQ-034 rst SHALL asynchronously force IDLE, result=0, done=0, busy=0, mm_start=0, op_count=0, operands=0.
REQ-035 rst mid-run SHALL abandon the run without a done pulse; a later mm_done SHALL be ignored.

Verification (behavioural core model: result=a*b*R^-1 mod m, latency 5 cycles; WIDTH=16, EXP_BITS=8, R=2^16)
- x=3, e=5, m=13 -> 4 mm_start pulses (SQ,SQ,MUL,FIN), result=9, op_count=4, one done pulse.
- e=0, m=13 -> SCAN 8 cycles, 1 op (FIN), result=1, op_count=1.
- e=1, x=7, m=13 -> 1 op, result=7; e=0xFF, x=2, m=251 -> 15 ops, result=2^255 mod 251.
- start pulsed while busy and in_e changed mid-run -> no effect; result matches original e.
- rst asserted during MUL wait, then mm_done -> no done, busy=0, all outputs 0; next run is correct.
- Spurious mm_done in SCAN/IDLE -> ignored; operands checked stable from mm_start to mm_done every op.
